// File: rtl/cpu_bus_unit.sv
// Bus interface stage: runs each M-cycle as four T-states, drives the
// external bus, captures read data / opcodes, and emits the M-cycle tick.
module cpu_bus_unit #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        bus_op,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_dout,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [DATA_W-1:0] ext_dout,
    input  logic [DATA_W-1:0] ext_din,
    output logic              ext_rd,
    output logic              ext_wr,
    input  logic              ext_ready,
    output logic [1:0]        tstate,
    output logic              m_tick,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] ir,
    output logic              cb_mode,
    output logic              ir_load,
    output logic              bus_timeout
);

    typedef enum logic [2:0] {
        OP_IDLE  = 3'd0,
        OP_IF    = 3'd1,
        OP_WRITE = 3'd2,
        OP_READ  = 3'd3,
        OP_IF_CB = 3'd4
    } bus_opcode_t;

    typedef enum logic [1:0] {
        T1 = 2'd0,
        T2 = 2'd1,
        T3 = 2'd2,
        T4 = 2'd3
    } tstate_t;

    localparam logic [7:0] MAXW = 8'(MAX_WAIT);

    tstate_t     state;
    bus_opcode_t op;
    logic [7:0]  wcnt;

    bus_opcode_t op_in;
    logic        hold;
    logic        timed_out;
    logic        fetch;
    logic [DATA_W-1:0] cap;

    function automatic logic reads(input bus_opcode_t o);
        return (o == OP_IF) || (o == OP_READ) || (o == OP_IF_CB);
    endfunction

    always_comb begin
        op_in     = (bus_op > 3'd4) ? OP_IDLE : bus_opcode_t'(bus_op);
        hold      = (op != OP_IDLE) && !ext_ready && (wcnt < MAXW);
        timed_out = (op != OP_IDLE) && (wcnt >= MAXW);
        fetch     = (op == OP_IF) || (op == OP_IF_CB);
        cap       = timed_out ? '1 : ext_din;
    end

    assign tstate = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= T1;
            op          <= OP_IDLE;
            wcnt        <= '0;
            ext_addr    <= '0;
            ext_dout    <= '0;
            ext_rd      <= 1'b0;
            ext_wr      <= 1'b0;
            m_tick      <= 1'b0;
            rdata       <= '1;
            ir          <= '0;
            cb_mode     <= 1'b0;
            ir_load     <= 1'b0;
            bus_timeout <= 1'b0;
        end else begin
            m_tick      <= 1'b0;
            ir_load     <= 1'b0;
            bus_timeout <= 1'b0;
            unique case (state)
                T1: begin
                    state  <= T2;
                    wcnt   <= '0;
                    ext_wr <= (op == OP_WRITE);
                end
                T2: begin
                    state <= T3;
                end
                T3: begin
                    if (hold) begin
                        wcnt <= wcnt + 8'd1;
                    end else begin
                        state       <= T4;
                        ext_rd      <= 1'b0;
                        ext_wr      <= 1'b0;
                        m_tick      <= 1'b1;
                        ir_load     <= fetch;
                        bus_timeout <= timed_out;
                        if (op == OP_READ)
                            rdata <= cap;
                        if (fetch) begin
                            ir      <= cap;
                            cb_mode <= (op == OP_IF_CB);
                        end
                    end
                end
                T4: begin
                    // next request is sampled only on the edge into T1
                    state  <= T1;
                    op     <= op_in;
                    ext_rd <= reads(op_in);
                    if (op_in != OP_IDLE)
                        ext_addr <= bus_addr;
                    if (op_in == OP_WRITE)
                        ext_dout <= bus_dout;
                end
                default: state <= T1;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_unit.sv
// Directed testbench for cpu_bus_unit: table of M-cycles plus a
// mid-cycle reset sequence.
module tb_cpu_bus_unit;

    logic        clk;
    logic        rst;
    logic [2:0]  bus_op;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dout;
    logic [15:0] ext_addr;
    logic [7:0]  ext_dout;
    logic [7:0]  ext_din;
    logic        ext_rd;
    logic        ext_wr;
    logic        ext_ready;
    logic [1:0]  tstate;
    logic        m_tick;
    logic [7:0]  rdata;
    logic [7:0]  ir;
    logic        cb_mode;
    logic        ir_load;
    logic        bus_timeout;

    int checks = 0;
    int failures = 0;

    cpu_bus_unit #(.ADDR_W(16), .DATA_W(8), .MAX_WAIT(15)) dut (
        .clk(clk), .rst(rst),
        .bus_op(bus_op), .bus_addr(bus_addr), .bus_dout(bus_dout),
        .ext_addr(ext_addr), .ext_dout(ext_dout), .ext_din(ext_din),
        .ext_rd(ext_rd), .ext_wr(ext_wr), .ext_ready(ext_ready),
        .tstate(tstate), .m_tick(m_tick), .rdata(rdata), .ir(ir),
        .cb_mode(cb_mode), .ir_load(ir_load), .bus_timeout(bus_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] addr;
        logic [7:0]  dout;
        logic [7:0]  din;
        int          waits;
        int          len;
        int          rdc;
        int          wrc;
        logic [15:0] eaddr;
        logic [7:0]  erdata;
        logic [7:0]  eir;
        logic        ecb;
        logic        eload;
        logic        etmo;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sync_t4();
        int n = 0;
        while (tstate !== 2'd3 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("sync_t4", 32'(tstate), 32'd3);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int len = 0, rdc = 0, wrc = 0, mt = 0, ld = 0, to = 0;
        int aerr = 0, derr = 0, ovl = 0, wc = 0;
        bus_op   = v.op;
        bus_addr = v.addr;
        bus_dout = v.dout;
        ext_ready = 1'b0;
        ext_din  = 8'hC3;
        do begin
            @(negedge clk);
            len++;
            bus_op   = 3'd2;
            bus_addr = 16'hDEAD;
            bus_dout = 8'h5C;
            rdc += int'(ext_rd);
            wrc += int'(ext_wr);
            mt  += int'(m_tick);
            ld  += int'(ir_load);
            to  += int'(bus_timeout);
            if (ext_addr !== v.eaddr) aerr++;
            if (v.op == 3'd2 && ext_dout !== v.dout) derr++;
            if (ext_rd && ext_wr) ovl++;
            if (tstate == 2'd2) begin
                ext_din   = v.din;
                ext_ready = (wc < v.waits) ? 1'b0 : 1'b1;
                if (!ext_ready) wc++;
            end else begin
                ext_din   = 8'hC3;
                ext_ready = 1'b0;
            end
        end while (tstate !== 2'd3 && len < 40);
        chk($sformatf("v%0d_len", idx), 32'(len), 32'(v.len));
        chk($sformatf("v%0d_rd_clks", idx), 32'(rdc), 32'(v.rdc));
        chk($sformatf("v%0d_wr_clks", idx), 32'(wrc), 32'(v.wrc));
        chk($sformatf("v%0d_m_ticks", idx), 32'(mt), 32'd1);
        chk($sformatf("v%0d_ir_loads", idx), 32'(ld), 32'(v.eload));
        chk($sformatf("v%0d_timeouts", idx), 32'(to), 32'(v.etmo));
        chk($sformatf("v%0d_addr_errs", idx), 32'(aerr), 32'd0);
        chk($sformatf("v%0d_dout_errs", idx), 32'(derr), 32'd0);
        chk($sformatf("v%0d_rd_wr_overlap", idx), 32'(ovl), 32'd0);
        chk($sformatf("v%0d_m_tick_t4", idx), 32'(m_tick), 32'd1);
        chk($sformatf("v%0d_ir_load_t4", idx), 32'(ir_load), 32'(v.eload));
        chk($sformatf("v%0d_timeout_t4", idx), 32'(bus_timeout), 32'(v.etmo));
        chk($sformatf("v%0d_rdata", idx), 32'(rdata), 32'(v.erdata));
        chk($sformatf("v%0d_ir", idx), 32'(ir), 32'(v.eir));
        chk($sformatf("v%0d_cb_mode", idx), 32'(cb_mode), 32'(v.ecb));
    endtask

    initial begin
        vec_t ifv;
        //          op    addr      dout   din    wt  len rd wr eaddr     rdata  ir     cb ld to
        vecs[0] = '{3'd0, 16'h1111, 8'h00, 8'h00, 0,   4, 0, 0, 16'h0000, 8'hFF, 8'h00, 0, 0, 0};
        vecs[1] = '{3'd7, 16'h2222, 8'h00, 8'h00, 3,   4, 0, 0, 16'h0000, 8'hFF, 8'h00, 0, 0, 0};
        vecs[2] = '{3'd1, 16'h0150, 8'h00, 8'h3E, 0,   4, 3, 0, 16'h0150, 8'hFF, 8'h3E, 0, 1, 0};
        vecs[3] = '{3'd4, 16'h0151, 8'h00, 8'h7C, 0,   4, 3, 0, 16'h0151, 8'hFF, 8'h7C, 1, 1, 0};
        vecs[4] = '{3'd3, 16'hFF44, 8'h00, 8'h91, 0,   4, 3, 0, 16'hFF44, 8'h91, 8'h7C, 1, 0, 0};
        vecs[5] = '{3'd2, 16'hC000, 8'hA5, 8'hEE, 2,   6, 0, 4, 16'hC000, 8'h91, 8'h7C, 1, 0, 0};
        vecs[6] = '{3'd0, 16'h3333, 8'h00, 8'h00, 0,   4, 0, 0, 16'hC000, 8'h91, 8'h7C, 1, 0, 0};
        vecs[7] = '{3'd3, 16'h8000, 8'h00, 8'h12, 255, 19, 18, 0, 16'h8000, 8'hFF, 8'h7C, 1, 0, 1};
        vecs[8] = '{3'd1, 16'h0152, 8'h00, 8'h00, 1,   5, 4, 0, 16'h0152, 8'hFF, 8'h00, 0, 1, 0};
        vecs[9] = '{3'd3, 16'h0153, 8'h00, 8'h5A, 0,   4, 3, 0, 16'h0153, 8'h5A, 8'h00, 0, 0, 0};
        ifv     = '{3'd1, 16'h0200, 8'h00, 8'h21, 0,   4, 3, 0, 16'h0200, 8'hFF, 8'h21, 0, 1, 0};

        rst = 1'b1;
        bus_op = 3'd0;
        bus_addr = 16'h0;
        bus_dout = 8'h0;
        ext_din = 8'h0;
        ext_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tstate", 32'(tstate), 32'd0);
        chk("rst_rd_wr", {30'd0, ext_rd, ext_wr}, 32'd0);
        chk("rst_addr", 32'(ext_addr), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'hFF);
        chk("rst_ir", 32'(ir), 32'h00);
        chk("rst_pulses", {29'd0, m_tick, ir_load, bus_timeout}, 32'd0);
        rst = 1'b0;
        sync_t4();

        for (int i = 0; i < 10; i++)
            run_vec(vecs[i], i);

        // reset in T2 of a write
        bus_op = 3'd2;
        bus_addr = 16'hD000;
        bus_dout = 8'h77;
        @(negedge clk);
        bus_op = 3'd0;
        @(negedge clk);
        chk("mid_t2_state", 32'(tstate), 32'd1);
        chk("mid_t2_wr", 32'(ext_wr), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_wr", 32'(ext_wr), 32'd0);
        chk("mid_rst_rd", 32'(ext_rd), 32'd0);
        chk("mid_rst_tstate", 32'(tstate), 32'd0);
        chk("mid_rst_rdata", 32'(rdata), 32'hFF);
        chk("mid_rst_ir", 32'(ir), 32'h00);
        chk("mid_rst_cb", 32'(cb_mode), 32'd0);
        chk("mid_rst_tick", 32'(m_tick), 32'd0);
        rst = 1'b0;
        sync_t4();
        run_vec(ifv, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_bus_unit.md
Name: cpu_bus_unit

Overview:
- Bus interface stage directly downstream of the control unit's per-M-cycle bus request (bus_opcode_t: IDLE, IF, WRITE, READ, IF_CB).
- Sequences each M-cycle as four T-states: drives the external address/data/strobe bus, captures read data and fetched opcodes, and emits the M-cycle tick that advances the control unit.
- Supports external wait states with a timeout.

Parameters:
- ADDR_W, 16, external address width.
- DATA_W, 8, data bus width.
- MAX_WAIT, 15, maximum extra T3 cycles before a forced bus timeout (range 1..255).

Ports:
- clk  in  1  system clock; one clk = one T-state.
- rst  in  1  synchronous reset, active-high.
- bus_op  in  3  bus_opcode_t request; sampled only in T1.
- bus_addr  in  ADDR_W  request address; sampled in T1.
- bus_dout  in  DATA_W  write data; sampled in T1.
- ext_addr  out  ADDR_W  external address.
- ext_dout  out  DATA_W  external write data.
- ext_din  in  DATA_W  external read data.
- ext_rd  out  1  read strobe.
- ext_wr  out  1  write strobe.
- ext_ready  in  1  device ready; low in T3 inserts a wait state.
- tstate  out  2  current T-state: 0=T1, 1=T2, 2=T3, 3=T4.
- m_tick  out  1  one-clk pulse in T4; M-cycle complete.
- rdata  out  DATA_W  last READ data.
- ir  out  DATA_W  instruction register.
- cb_mode  out  1  ir holds a CB-prefixed opcode.
- ir_load  out  1  one-clk pulse in T4 of IF/IF_CB cycles.
- bus_timeout  out  1  one-clk pulse in T4 of a timed-out M-cycle.

Behaviour:
- Reset values (held while rst=1, applied on the next clk edge):
  - tstate=T1; ext_addr=0; ext_dout=0; ext_rd=0; ext_wr=0.
  - m_tick=0; rdata=0xFF; ir=0x00 (NOP); cb_mode=0; ir_load=0; bus_timeout=0.
  - Internal op latch = IDLE; wait counter = 0.
- T-state machine:
  - T1→T2→T3→T4→T1 free-running.
  - T3 holds while ext_ready=0 and wait counter < MAX_WAIT.
  - ext_ready is ignored outside T3 and for IDLE cycles.
- Request latching:
  - On the clk edge that enters T1, latch bus_op, bus_addr and bus_dout.
  - Requests are sampled only then; later input changes within the M-cycle have no effect.
  - Encodings 5..7 are treated as IDLE.
- Strobe timing:
  - ext_addr is valid from T1 through T4 of the latched cycle. For IDLE it holds its previous value.
  - READ/IF/IF_CB: ext_rd=1 during T1..T3, including wait states.
  - WRITE: ext_dout valid T1..T4; ext_wr=1 in T2..T3, including wait states.
  - ext_rd and ext_wr are never asserted simultaneously.
- Data capture, on the edge leaving T3 (ext_ready=1 or timeout):
  - READ: rdata←ext_din.
  - IF: ir←ext_din, cb_mode←0.
  - IF_CB: ir←ext_din, cb_mode←1.
  - rdata, ir and cb_mode are otherwise unchanged.
- Timeout:
  - Wait counter increments each T3 clk with ext_ready=0.
  - When it reaches MAX_WAIT, T3 is exited regardless of ext_ready and the captured value is 0xFF instead of ext_din.
  - For WRITE the strobe drops normally.
  - bus_timeout pulses in T4. Wait counter clears in T1.
- Pulses:
  - m_tick=1 exactly in T4, once per M-cycle, including IDLE.
  - ir_load=1 in T4 of IF/IF_CB cycles only.
- Latency: a non-waited M-cycle is 4 clk; each wait state adds 1 clk.
- Reset mid-cycle: strobes drop to 0 on the reset edge; no partial capture; after rst deasserts the sequence restarts at T1.

Test Plan:
- Reset, then IDLE requests → m_tick pulses every 4 clk; ext_rd=ext_wr=0; ir=0x00; rdata=0xFF.
- IF at addr 0x0150, ext_din=0x3E, ext_ready=1 → ext_rd high T1..T3, ext_addr=0x0150; in T4 ir=0x3E, cb_mode=0, ir_load=1, m_tick=1.
- IF_CB with ext_din=0x7C, then READ at 0xFF44 with ext_din=0x91 → ir=0x7C, cb_mode=1; rdata=0x91; ir unchanged after the READ.
- WRITE 0xC000←0xA5, ext_ready low for 2 clk in T3 → ext_wr high T2 plus 3 T3 clk, ext_dout=0xA5 throughout; M-cycle lasts 6 clk; single m_tick.
- READ with ext_ready held 0, MAX_WAIT=15 → T3 lasts 16 clk; rdata=0xFF; bus_timeout and m_tick pulse together in T4.
- rst asserted in T2 of a WRITE → ext_wr=0 next clk, tstate=T1; rdata/ir at reset values; the following IF completes normally.
